// File: rtl/hyperram_resp.sv
// HyperRAM responder model: accepts a 48-bit command/address (CA) sequence
// from a host, waits the configured latency, then streams read data or
// accepts write data for a small internal memory or the register space.
// Optional feature: define HYPERRAM_RESP_STATS_EN to add 16-bit read/write
// transaction counters readable at register addresses 2 and 3.
module hyperram_resp #(
   parameter int          DEPTH   = 256,
   parameter int          ADDR_W  = 8,
   parameter int          RD_LAT  = 16,
   parameter int          WR_LAT  = 13,
   parameter logic [15:0] ID0     = 16'h0C81,
   parameter logic [15:0] CR0_RST = 16'h8F1F
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        csn,
   input  logic [15:0] dq_in,
   input  logic        dq_oe_host,
   input  logic        rwds_in,
   input  logic        rwds_oe_host,
   output logic [15:0] dq_out,
   output logic        dq_oe,
   output logic        rwds_out,
   output logic        rwds_oe,
   output logic        busy,
   output logic [15:0] cr0
);

   localparam int LAT_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      CA,
      LAT,
      DATA
   } state_t;

   state_t            state_q, state_d;
   logic [47:0]       ca_q, ca_d, ca_next;
   logic [1:0]        ca_cnt_q, ca_cnt_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic              is_read_q, is_read_d;
   logic              is_reg_q, is_reg_d;
   logic              reg_done_q, reg_done_d;
   logic [ADDR_W-1:0] addr_q, addr_d, addr_inc, ca_addr;
   logic [31:0]       ca_addr_vec;
   logic [15:0]       dq_out_q, dq_out_d;
   logic              dq_oe_q, dq_oe_d;
   logic              rwds_out_q, rwds_out_d;
   logic              rwds_oe_q, rwds_oe_d;
   logic              busy_q, busy_d;
   logic [15:0]       cr0_q, cr0_d;
   logic              mem_we;
   logic [15:0]       mem_rdata, reg_rdata, rd_word;
   logic [15:0]       rd_cnt_view, wr_cnt_view;
   logic              ca_unused;

   logic [15:0]       mem [DEPTH];

   // The shift register view including the word currently on dq_in, so the
   // third word can be decoded in the same cycle it is sampled.
   assign ca_next     = {ca_q[31:0], dq_in};
   assign ca_addr_vec = {ca_next[44:16], ca_next[2:0]};
   assign ca_addr     = ca_addr_vec[ADDR_W-1:0];
   assign ca_unused   = ^{ca_q[47:32], ca_next[45], ca_next[15:3], ca_addr_vec[31:ADDR_W]};

   assign addr_inc  = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
   assign mem_rdata = mem[addr_q];

`ifdef HYPERRAM_RESP_STATS_EN
   logic [15:0] rd_cnt, wr_cnt;
   logic        rd_inc, wr_inc;

   // A transaction counts once, on the cycle it enters DATA; aborts before
   // that point never count.
   always_comb begin
      rd_inc = 1'b0;
      wr_inc = 1'b0;
      if (!csn) begin
         if (state_q == LAT && lat_q == '0) begin
            rd_inc = is_read_q;
            wr_inc = !is_read_q;
         end
         if (state_q == CA && dq_oe_host && ca_cnt_q == 2'd2 &&
             !ca_next[47] && ca_next[46]) begin
            wr_inc = 1'b1;
         end
      end
   end

   // Wrapping statistics counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else begin
         if (rd_inc) rd_cnt <= rd_cnt + 16'd1;
         if (wr_inc) wr_cnt <= wr_cnt + 16'd1;
      end
   end

   // The read counter view includes the read entering DATA right now, so the
   // value returned is the same on every word of the burst.
   assign rd_cnt_view = rd_cnt + {15'd0, rd_inc};
   assign wr_cnt_view = wr_cnt;
`else
   assign rd_cnt_view = 16'h0000;
   assign wr_cnt_view = 16'h0000;
`endif

   // Register-space read multiplexer.
   always_comb begin
      reg_rdata = 16'h0000;
      case (addr_q)
         ADDR_W'(0): reg_rdata = ID0;
         ADDR_W'(1): reg_rdata = cr0_q;
         ADDR_W'(2): reg_rdata = rd_cnt_view;
         ADDR_W'(3): reg_rdata = wr_cnt_view;
         default:    reg_rdata = 16'h0000;
      endcase
   end

   assign rd_word = is_reg_q ? reg_rdata : mem_rdata;

   // Next-state and next-output logic; a csn rise in any active state
   // overrides everything and returns to IDLE with outputs released.
   always_comb begin
      state_d    = state_q;
      ca_d       = ca_q;
      ca_cnt_d   = ca_cnt_q;
      lat_d      = lat_q;
      is_read_d  = is_read_q;
      is_reg_d   = is_reg_q;
      reg_done_d = reg_done_q;
      addr_d     = addr_q;
      cr0_d      = cr0_q;
      dq_out_d   = dq_out_q;
      dq_oe_d    = dq_oe_q;
      rwds_out_d = rwds_out_q;
      rwds_oe_d  = rwds_oe_q;
      mem_we     = 1'b0;

      case (state_q)
         IDLE: begin
            dq_oe_d = 1'b0;
            if (!csn) begin
               state_d    = CA;
               ca_cnt_d   = '0;
               rwds_oe_d  = 1'b1;
               rwds_out_d = 1'b1;
            end else begin
               rwds_oe_d  = 1'b0;
               rwds_out_d = 1'b0;
            end
         end
         CA: begin
            if (dq_oe_host) begin
               ca_d     = ca_next;
               ca_cnt_d = ca_cnt_q + 2'd1;
               if (ca_cnt_q == 2'd2) begin
                  is_read_d  = ca_next[47];
                  is_reg_d   = ca_next[46];
                  addr_d     = ca_addr;
                  reg_done_d = 1'b0;
                  rwds_oe_d  = 1'b0;
                  rwds_out_d = 1'b0;
                  if (!ca_next[47] && ca_next[46]) begin
                     state_d = DATA;
                  end else begin
                     state_d = LAT;
                     lat_d   = ca_next[47] ? LAT_W'(RD_LAT - 1) : LAT_W'(WR_LAT - 1);
                  end
               end
            end
         end
         LAT: begin
            if (lat_q == '0) begin
               state_d = DATA;
               if (is_read_q) begin
                  dq_out_d   = rd_word;
                  dq_oe_d    = 1'b1;
                  rwds_oe_d  = 1'b1;
                  rwds_out_d = 1'b1;
                  if (!is_reg_q) addr_d = addr_inc;
               end
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         DATA: begin
            if (is_read_q) begin
               dq_out_d   = rd_word;
               dq_oe_d    = 1'b1;
               rwds_oe_d  = 1'b1;
               rwds_out_d = 1'b1;
               if (!is_reg_q) addr_d = addr_inc;
            end else if (is_reg_q) begin
               if (dq_oe_host && !reg_done_q) begin
                  reg_done_d = 1'b1;
                  if (addr_q == ADDR_W'(1)) cr0_d = dq_in;
               end
            end else if (dq_oe_host) begin
               mem_we = !(rwds_oe_host && rwds_in);
               addr_d = addr_inc;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE && csn) begin
         state_d    = IDLE;
         addr_d     = addr_q;
         cr0_d      = cr0_q;
         dq_out_d   = 16'h0000;
         dq_oe_d    = 1'b0;
         rwds_out_d = 1'b0;
         rwds_oe_d  = 1'b0;
         mem_we     = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   // State and registered outputs; reset wins over any host activity.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ca_q       <= '0;
         ca_cnt_q   <= '0;
         lat_q      <= '0;
         is_read_q  <= 1'b0;
         is_reg_q   <= 1'b0;
         reg_done_q <= 1'b0;
         addr_q     <= '0;
         cr0_q      <= CR0_RST;
         dq_out_q   <= 16'h0000;
         dq_oe_q    <= 1'b0;
         rwds_out_q <= 1'b0;
         rwds_oe_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ca_q       <= ca_d;
         ca_cnt_q   <= ca_cnt_d;
         lat_q      <= lat_d;
         is_read_q  <= is_read_d;
         is_reg_q   <= is_reg_d;
         reg_done_q <= reg_done_d;
         addr_q     <= addr_d;
         cr0_q      <= cr0_d;
         dq_out_q   <= dq_out_d;
         dq_oe_q    <= dq_oe_d;
         rwds_out_q <= rwds_out_d;
         rwds_oe_q  <= rwds_oe_d;
         busy_q     <= busy_d;
      end
   end

   // Memory array write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) mem[addr_q] <= dq_in;
   end

   assign dq_out   = dq_out_q;
   assign dq_oe    = dq_oe_q;
   assign rwds_out = rwds_out_q;
   assign rwds_oe  = rwds_oe_q;
   assign busy     = busy_q;
   assign cr0      = cr0_q;

endmodule

// File: tb/tb_hyperram_resp.sv
// Directed self-checking bench for hyperram_resp: reset, CA handshake,
// read/write latency, masking, address wrap, register space and aborts.
module tb_hyperram_resp;

   localparam int RD_LAT = 16;
   localparam int WR_LAT = 13;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        csn = 1'b1;
   logic [15:0] dq_in = 16'h0000;
   logic        dq_oe_host = 1'b0;
   logic        rwds_in = 1'b0;
   logic        rwds_oe_host = 1'b0;
   logic [15:0] dq_out;
   logic        dq_oe;
   logic        rwds_out;
   logic        rwds_oe;
   logic        busy;
   logic [15:0] cr0;

   int          pass_cnt = 0;
   int          total_cnt = 0;
   int          exp_rd = 0;
   int          exp_wr = 0;
   logic [15:0] exp_val;

   logic [15:0] wr_words [4];
   logic        wr_mask  [4];
   logic [15:0] rd_words [8];
   logic        rd_oe    [8];

   hyperram_resp #(
      .DEPTH(256), .ADDR_W(8), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT),
      .ID0(16'h0C81), .CR0_RST(16'h8F1F)
   ) dut (
      .clk(clk), .rst(rst), .csn(csn), .dq_in(dq_in), .dq_oe_host(dq_oe_host),
      .rwds_in(rwds_in), .rwds_oe_host(rwds_oe_host), .dq_out(dq_out),
      .dq_oe(dq_oe), .rwds_out(rwds_out), .rwds_oe(rwds_oe), .busy(busy),
      .cr0(cr0)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic end_txn();
      csn = 1'b1;
      dq_oe_host = 1'b0;
      rwds_oe_host = 1'b0;
      rwds_in = 1'b0;
      tick();
   endtask

   // Returns one cycle after the third CA word was sampled.
   task automatic send_ca(input logic [47:0] ca, input bit gap);
      csn = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         dq_in = ca[47-16*i -: 16];
         dq_oe_host = 1'b1;
         tick();
         if (gap && i == 0) begin
            dq_oe_host = 1'b0;
            dq_in = 16'hFFFF;
            tick();
         end
      end
      dq_oe_host = 1'b0;
   endtask

   task automatic mem_write(input logic [47:0] ca, input int n);
      exp_wr++;
      send_ca(ca, 1'b0);
      repeat (WR_LAT) tick();
      for (int i = 0; i < n; i++) begin
         dq_in = wr_words[i];
         dq_oe_host = 1'b1;
         rwds_oe_host = 1'b1;
         rwds_in = wr_mask[i];
         tick();
      end
      end_txn();
   endtask

   task automatic mem_read(input logic [47:0] ca, input int n, input bit gap);
      exp_rd++;
      send_ca(ca, gap);
      repeat (RD_LAT - 1) tick();
      for (int i = 0; i < n; i++) begin
         tick();
         rd_words[i] = dq_out;
         rd_oe[i] = dq_oe;
      end
      end_txn();
   endtask

   task automatic reg_write(input logic [47:0] ca, input logic [15:0] w0, input logic [15:0] w1);
      exp_wr++;
      send_ca(ca, 1'b0);
      dq_in = w0;
      dq_oe_host = 1'b1;
      tick();
      dq_in = w1;
      tick();
      dq_oe_host = 1'b0;
      end_txn();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      csn = 1'b0;
      tick();
      tick();
      total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b expected 0", busy); else pass_cnt++;
      total_cnt++; if (rwds_oe !== 1'b0) $display("[TB] FAIL reset_rwds_oe: got %0b expected 0", rwds_oe); else pass_cnt++;
      total_cnt++; if (rwds_out !== 1'b0) $display("[TB] FAIL reset_rwds_out: got %0b expected 0", rwds_out); else pass_cnt++;
      total_cnt++; if (dq_oe !== 1'b0) $display("[TB] FAIL reset_dq_oe: got %0b expected 0", dq_oe); else pass_cnt++;
      total_cnt++; if (dq_out !== 16'h0000) $display("[TB] FAIL reset_dq_out: got %h expected 0000", dq_out); else pass_cnt++;
      total_cnt++; if (cr0 !== 16'h8F1F) $display("[TB] FAIL reset_cr0: got %h expected 8f1f", cr0); else pass_cnt++;
      csn = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL idle_after_reset_busy: got %0b expected 0", busy); else pass_cnt++;
   endtask

   task automatic test_ca_start();
      csn = 1'b0;
      tick();
      total_cnt++; if (rwds_oe !== 1'b1) $display("[TB] FAIL ca_rwds_oe: got %0b expected 1", rwds_oe); else pass_cnt++;
      total_cnt++; if (rwds_out !== 1'b1) $display("[TB] FAIL ca_rwds_out: got %0b expected 1", rwds_out); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("[TB] FAIL ca_busy: got %0b expected 1", busy); else pass_cnt++;
      dq_in = 16'h8000;
      dq_oe_host = 1'b1;
      tick();
      csn = 1'b1;
      dq_oe_host = 1'b0;
      tick();
      total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL ca_abort_busy: got %0b expected 0", busy); else pass_cnt++;
      total_cnt++; if (rwds_oe !== 1'b0) $display("[TB] FAIL ca_abort_rwds_oe: got %0b expected 0", rwds_oe); else pass_cnt++;
   endtask

   task automatic test_reg_read();
      exp_rd++;
      send_ca(48'hC000_0000_0000, 1'b0);
      total_cnt++; if (rwds_oe !== 1'b0) $display("[TB] FAIL rr_rwds_oe_drop: got %0b expected 0", rwds_oe); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("[TB] FAIL rr_busy_lat: got %0b expected 1", busy); else pass_cnt++;
      repeat (RD_LAT - 1) tick();
      total_cnt++; if (dq_oe !== 1'b0) $display("[TB] FAIL rr_early_dq_oe: got %0b expected 0", dq_oe); else pass_cnt++;
      tick();
      total_cnt++; if (dq_oe !== 1'b1) $display("[TB] FAIL rr_dq_oe: got %0b expected 1", dq_oe); else pass_cnt++;
      total_cnt++; if (dq_out !== 16'h0C81) $display("[TB] FAIL rr_id0: got %h expected 0c81", dq_out); else pass_cnt++;
      total_cnt++; if (rwds_oe !== 1'b1 || rwds_out !== 1'b1) $display("[TB] FAIL rr_rwds: got oe=%0b out=%0b expected 1/1", rwds_oe, rwds_out); else pass_cnt++;
      tick();
      total_cnt++; if (dq_out !== 16'h0C81) $display("[TB] FAIL rr_id0_repeat: got %h expected 0c81", dq_out); else pass_cnt++;
      end_txn();
      total_cnt++; if (busy !== 1'b0 || dq_oe !== 1'b0 || rwds_oe !== 1'b0) $display("[TB] FAIL rr_end: got busy=%0b dq_oe=%0b rwds_oe=%0b expected 0/0/0", busy, dq_oe, rwds_oe); else pass_cnt++;
   endtask

   task automatic test_mem_write_masked();
      wr_words[0] = 16'hA1A1; wr_words[1] = 16'hB2B2; wr_words[2] = 16'hC3C3; wr_words[3] = 16'hD4D4;
      for (int i = 0; i < 4; i++) wr_mask[i] = 1'b0;
      mem_write(48'h0000_0000_0002, 4);
      wr_words[0] = 16'h1111; wr_words[1] = 16'h2222; wr_words[2] = 16'h3333;
      wr_mask[1] = 1'b1;
      mem_write(48'h0000_0000_0002, 3);
      mem_read(48'h8000_0000_0002, 3, 1'b1);
      total_cnt++; if (rd_words[0] !== 16'h1111) $display("[TB] FAIL mw_addr2: got %h expected 1111", rd_words[0]); else pass_cnt++;
      total_cnt++; if (rd_words[1] !== 16'hB2B2) $display("[TB] FAIL mw_masked_addr3: got %h expected b2b2", rd_words[1]); else pass_cnt++;
      total_cnt++; if (rd_words[2] !== 16'h3333) $display("[TB] FAIL mw_addr4: got %h expected 3333", rd_words[2]); else pass_cnt++;
      total_cnt++; if (rd_oe[2] !== 1'b1) $display("[TB] FAIL mw_read_oe: got %0b expected 1", rd_oe[2]); else pass_cnt++;
   endtask

   task automatic test_wrap();
      wr_words[0] = 16'hFF00; wr_words[1] = 16'h0100; wr_words[2] = 16'h0101;
      for (int i = 0; i < 4; i++) wr_mask[i] = 1'b0;
      mem_write(48'h0000_001F_0007, 3);
      mem_read(48'h8000_001F_0007, 3, 1'b0);
      total_cnt++; if (rd_words[0] !== 16'hFF00) $display("[TB] FAIL wrap_mem255: got %h expected ff00", rd_words[0]); else pass_cnt++;
      total_cnt++; if (rd_words[1] !== 16'h0100) $display("[TB] FAIL wrap_mem0: got %h expected 0100", rd_words[1]); else pass_cnt++;
      total_cnt++; if (rd_words[2] !== 16'h0101) $display("[TB] FAIL wrap_mem1: got %h expected 0101", rd_words[2]); else pass_cnt++;
   endtask

   task automatic test_reg_write();
      reg_write(48'h4000_0000_0001, 16'h8F17, 16'hDEAD);
      total_cnt++; if (cr0 !== 16'h8F17) $display("[TB] FAIL rw_cr0_port: got %h expected 8f17", cr0); else pass_cnt++;
      mem_read(48'hC000_0000_0001, 2, 1'b0);
      total_cnt++; if (rd_words[0] !== 16'h8F17 || rd_words[1] !== 16'h8F17) $display("[TB] FAIL rw_cr0_read: got %h %h expected 8f17 8f17", rd_words[0], rd_words[1]); else pass_cnt++;
      reg_write(48'h4000_0000_0000, 16'h1234, 16'h5678);
      total_cnt++; if (cr0 !== 16'h8F17) $display("[TB] FAIL rw_addr0_cr0: got %h expected 8f17", cr0); else pass_cnt++;
      mem_read(48'hC000_0000_0000, 1, 1'b0);
      total_cnt++; if (rd_words[0] !== 16'h0C81) $display("[TB] FAIL rw_id0_kept: got %h expected 0c81", rd_words[0]); else pass_cnt++;
      mem_read(48'hC000_0000_0005, 1, 1'b0);
      total_cnt++; if (rd_words[0] !== 16'h0000) $display("[TB] FAIL rw_other_addr: got %h expected 0000", rd_words[0]); else pass_cnt++;
   endtask

   task automatic test_abort();
      send_ca(48'h0000_0000_0002, 1'b0);
      repeat (5) tick();
      total_cnt++; if (busy !== 1'b1) $display("[TB] FAIL ab_busy_lat: got %0b expected 1", busy); else pass_cnt++;
      dq_in = 16'hBAD0;
      dq_oe_host = 1'b1;
      csn = 1'b1;
      tick();
      total_cnt++; if (busy !== 1'b0 || dq_oe !== 1'b0 || rwds_oe !== 1'b0) $display("[TB] FAIL ab_lat_idle: got busy=%0b dq_oe=%0b rwds_oe=%0b expected 0/0/0", busy, dq_oe, rwds_oe); else pass_cnt++;
      dq_oe_host = 1'b0;
      tick();
      exp_wr++;
      send_ca(48'h0000_0000_0004, 1'b0);
      repeat (WR_LAT) tick();
      dq_in = 16'h7777;
      dq_oe_host = 1'b1;
      tick();
      dq_in = 16'h8888;
      csn = 1'b1;
      tick();
      total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL ab_data_idle: got %0b expected 0", busy); else pass_cnt++;
      dq_oe_host = 1'b0;
      tick();
      mem_read(48'h8000_0000_0002, 4, 1'b0);
      total_cnt++; if (rd_words[0] !== 16'h1111) $display("[TB] FAIL ab_mem2: got %h expected 1111", rd_words[0]); else pass_cnt++;
      total_cnt++; if (rd_words[1] !== 16'hB2B2) $display("[TB] FAIL ab_mem3: got %h expected b2b2", rd_words[1]); else pass_cnt++;
      total_cnt++; if (rd_words[2] !== 16'h7777) $display("[TB] FAIL ab_mem4: got %h expected 7777", rd_words[2]); else pass_cnt++;
      total_cnt++; if (rd_words[3] !== 16'hD4D4) $display("[TB] FAIL ab_mem5_csn_priority: got %h expected d4d4", rd_words[3]); else pass_cnt++;
   endtask

   task automatic test_stats();
      mem_read(48'hC000_0000_0002, 1, 1'b0);
`ifdef HYPERRAM_RESP_STATS_EN
      exp_val = 16'(exp_rd);
`else
      exp_val = 16'h0000;
`endif
      total_cnt++; if (rd_words[0] !== exp_val) $display("[TB] FAIL st_rd_cnt: got %h expected %h", rd_words[0], exp_val); else pass_cnt++;
      mem_read(48'hC000_0000_0003, 1, 1'b0);
`ifdef HYPERRAM_RESP_STATS_EN
      exp_val = 16'(exp_wr);
`else
      exp_val = 16'h0000;
`endif
      total_cnt++; if (rd_words[0] !== exp_val) $display("[TB] FAIL st_wr_cnt: got %h expected %h", rd_words[0], exp_val); else pass_cnt++;
      $display("[TB] model transaction counts rd=%0d wr=%0d", exp_rd, exp_wr);
   endtask

   task automatic test_reset_again();
      rst = 1'b1;
      tick();
      total_cnt++; if (cr0 !== 16'h8F1F) $display("[TB] FAIL rst2_cr0: got %h expected 8f1f", cr0); else pass_cnt++;
      rst = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_ca_start();
      test_reg_read();
      test_mem_write_masked();
      test_wrap();
      test_reg_write();
      test_abort();
      test_stats();
      test_reset_again();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
